// File: rtl/cpu_pkg.sv
// Shared sequencer constants: FSM state codes and opcode values used by
// the sequencer, the datapath and benches.
package cpu_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load wins over increment, otherwise hold; one-cycle update,
// wraps modulo 2^PC_W, no backpressure.
module pc_reg #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end else if (inc_en) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer; 3 cycles fetch-to-fetch (4 for ALU ops),
// FETCH stalls indefinitely while imem_ready is low.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 4,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [IW-1:0]   instr_rdata,
    input  logic            imem_ready,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic [IW-1:0]   ir,
    output logic            alu_en,
    output logic            reg_we,
    output logic            halted,
    output logic [2:0]      state
);

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [IW-1:0]   ir_q;
    logic [IW-1:0]   ir_d;
    logic            pc_load;
    logic            pc_inc;
    logic [3:0]      opcode;
    logic [PC_W-1:0] imm_pc;

    assign opcode = opcode_of(ir_q[15:0]);
    // Size cast zero-extends or truncates the 4-bit immediate to the PC width.
    assign imm_pc = PC_W'(ir_q[3:0]);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP:  pc_inc = 1'b1;
                    OP_JMP:  pc_load = 1'b1;
                    OP_BEQZ: begin
                        pc_load = zero_flag;
                        pc_inc  = ~zero_flag;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_WRITEBACK: begin
                pc_inc  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    pc_reg #(
        .PC_W (PC_W)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load_en  (pc_load),
        .load_val (imm_pc),
        .inc_en   (pc_inc),
        .pc       (pc)
    );

    // Strobes come straight from the state register so no input reaches them.
    assign imem_req = (state_q == S_FETCH);
    assign alu_en   = (state_q == S_EXECUTE);
    assign reg_we   = (state_q == S_WRITEBACK);
    assign halted   = (state_q == S_HALT);
    assign state    = state_q;
    assign ir       = ir_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized program run,
// each instruction checked against a per-instruction reference model.
module tb_fetch_sequencer;

    localparam int PC_W = 4;
    localparam int IW   = 16;
    localparam int NPC  = 2 ** PC_W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            run = 1'b0;
    logic            imem_ready = 1'b1;
    logic            zero_flag = 1'b0;
    logic [IW-1:0]   instr_rdata;
    logic [PC_W-1:0] pc;
    logic            imem_req;
    logic [IW-1:0]   ir;
    logic            alu_en;
    logic            reg_we;
    logic            halted;
    logic [2:0]      state;

    logic [15:0] mem [NPC];
    int checks = 0;
    int errors = 0;

    assign instr_rdata = mem[pc];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PC_W (PC_W),
        .IW   (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr_rdata (instr_rdata),
        .imem_ready  (imem_ready),
        .zero_flag   (zero_flag),
        .pc          (pc),
        .imem_req    (imem_req),
        .ir          (ir),
        .alu_en      (alu_en),
        .reg_we      (reg_we),
        .halted      (halted),
        .state       (state)
    );

    // Reference model: architectural effect of one instruction.
    function automatic int model_next_pc(input int cur, input logic [15:0] ins, input logic zf);
        int op;
        int imm;
        op  = int'(ins[15:12]);
        imm = int'(ins[3:0]) % NPC;
        if (op == 15) return cur;
        if (op == 10) return imm;
        if (op == 11) return zf ? imm : (cur + 1) % NPC;
        return (cur + 1) % NPC;
    endfunction

    function automatic int model_cycles(input logic [15:0] ins);
        int op;
        op = int'(ins[15:12]);
        if (op == 15) return 2;
        if (op == 0 || op == 10 || op == 11) return 3;
        return 4;
    endfunction

    function automatic logic [15:0] rand_instr_no_halt();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hF) w[15:12] = 4'h0;
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NPC; i++) mem[i] = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        run = 1'b0;
        imem_ready = 1'b1;
        zero_flag = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL start_fetch state=%0d imem_req=%b required state=1 imem_req=1", state, imem_req);
        end
    endtask

    // Runs one instruction from FETCH to the next FETCH (or HALT entry).
    task automatic step(input int stall, input logic zf);
        int p;
        int cyc;
        int na;
        int nw;
        int exp_pc;
        bit done;
        logic [15:0] ins;
        p = int'(pc);
        ins = mem[p];
        zero_flag = zf;
        cyc = 0;
        na = 0;
        nw = 0;
        done = 1'b0;
        for (int k = 0; k < stall; k++) begin
            imem_ready = 1'b0;
            tick();
            cyc++;
            na += int'(alu_en);
            nw += int'(reg_we);
        end
        imem_ready = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            cyc++;
            na += int'(alu_en);
            nw += int'(reg_we);
            if (imem_req === 1'b1 || halted === 1'b1) done = 1'b1;
        end
        exp_pc = model_next_pc(p, ins, zf);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL step_timeout pc=%0d instr=%h: no FETCH/HALT within 20 cycles", p, ins);
        end
        checks++;
        if (int'(pc) != exp_pc) begin
            errors++;
            $display("FAIL step_pc instr=%h at %0d zf=%b: got pc=%0d required %0d", ins, p, zf, pc, exp_pc);
        end
        checks++;
        if (cyc != model_cycles(ins) + stall) begin
            errors++;
            $display("FAIL step_cycles instr=%h stall=%0d: got %0d required %0d", ins, stall, cyc, model_cycles(ins) + stall);
        end
        checks++;
        if (na != ((ins[15:12] == 4'hF) ? 0 : 1)) begin
            errors++;
            $display("FAIL step_alu_en instr=%h: got %0d pulses required %0d", ins, na, (ins[15:12] == 4'hF) ? 0 : 1);
        end
        checks++;
        if (nw != (model_cycles(ins) == 4 ? 1 : 0)) begin
            errors++;
            $display("FAIL step_reg_we instr=%h: got %0d pulses required %0d", ins, nw, model_cycles(ins) == 4 ? 1 : 0);
        end
        checks++;
        if (ir !== ins) begin
            errors++;
            $display("FAIL step_ir: got %h required %h", ir, ins);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (state !== 3'd0 || pc !== '0 || ir !== '0) begin
            errors++;
            $display("FAIL reset_regs state=%0d pc=%0d ir=%h required 0 0 0000", state, pc, ir);
        end
        checks++;
        if ({imem_req, alu_en, reg_we, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b required 0000", {imem_req, alu_en, reg_we, halted});
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state !== 3'd0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d state=%0d imem_req=%b required 0 0", i, state, imem_req);
            end
        end
    endtask

    task automatic test_nop();
        clear_mem();
        do_reset();
        start();
        for (int i = 0; i < 3; i++) step(0, 1'b0);
    endtask

    task automatic test_alu();
        clear_mem();
        mem[0] = 16'h1230;
        do_reset();
        start();
        tick();
        tick();
        checks++;
        if (alu_en !== 1'b1 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_execute alu_en=%b reg_we=%b required 1 0", alu_en, reg_we);
        end
        tick();
        checks++;
        if (alu_en !== 1'b0 || reg_we !== 1'b1 || pc !== 4'd0) begin
            errors++;
            $display("FAIL alu_writeback alu_en=%b reg_we=%b pc=%0d required 0 1 0", alu_en, reg_we, pc);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || pc !== 4'd1 || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_refetch imem_req=%b pc=%0d reg_we=%b required 1 1 0", imem_req, pc, reg_we);
        end
    endtask

    task automatic test_branches();
        clear_mem();
        mem[0] = 16'hA00F;
        do_reset();
        start();
        step(0, 1'b0);
        step(0, 1'b0);
        clear_mem();
        mem[2] = 16'hA007;
        do_reset();
        start();
        for (int i = 0; i < 3; i++) step(0, 1'b1);
        clear_mem();
        mem[0] = 16'hB00C;
        do_reset();
        start();
        step(0, 1'b1);
        do_reset();
        start();
        step(0, 1'b0);
    endtask

    task automatic test_stall();
        clear_mem();
        do_reset();
        start();
        step(0, 1'b0);
        mem[1] = 16'h5ABC;
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || state !== 3'd1 || pc !== 4'd1 || ir !== 16'h0000) begin
                errors++;
                $display("FAIL stall cycle %0d imem_req=%b state=%0d pc=%0d ir=%h required 1 1 1 0000", i, imem_req, state, pc, ir);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if (state !== 3'd2 || ir !== 16'h5ABC || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_release state=%0d ir=%h imem_req=%b required 2 5abc 0", state, ir, imem_req);
        end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[3] = 16'hF000;
        do_reset();
        start();
        for (int i = 0; i < 4; i++) step(0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom);
            tick();
            checks++;
            if (halted !== 1'b1 || pc !== 4'd3 || state !== 3'd5 || imem_req !== 1'b0 || ir !== 16'hF000) begin
                errors++;
                $display("FAIL halt_hold cycle %0d halted=%b pc=%0d state=%0d imem_req=%b ir=%h required 1 3 5 0 f000",
                         i, halted, pc, state, imem_req, ir);
            end
        end
        run = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || pc !== '0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset state=%0d pc=%0d halted=%b required 0 0 0", state, pc, halted);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        int we_cnt;
        clear_mem();
        mem[0] = 16'hA005;
        mem[5] = 16'h1230;
        do_reset();
        start();
        step(0, 1'b0);
        tick();
        tick();
        checks++;
        if (state !== 3'd3 || alu_en !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup state=%0d alu_en=%b required 3 1", state, alu_en);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || pc !== '0 || ir !== '0 || {imem_req, alu_en, reg_we, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_immediate state=%0d pc=%0d ir=%h strobes=%b required 0 0 0000 0000",
                     state, pc, ir, {imem_req, alu_en, reg_we, halted});
        end
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            we_cnt += int'(reg_we);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            we_cnt += int'(reg_we);
        end
        checks++;
        if (we_cnt != 0 || state !== 3'd0) begin
            errors++;
            $display("FAIL areset_abandon reg_we pulses=%0d state=%0d required 0 0", we_cnt, state);
        end
    endtask

    task automatic test_random_program();
        for (int i = 0; i < NPC; i++) mem[i] = rand_instr_no_halt();
        do_reset();
        start();
        for (int i = 0; i < 40; i++) step(int'($urandom_range(0, 2)), 1'($urandom));
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_nop();
        test_alu();
        test_branches();
        test_stall();
        test_halt();
        test_async_reset();
        test_random_program();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
